// File: rtl/esm_candidate_selector.sv
`default_nettype none
// ============================================================================
//  Module      : esm_candidate_selector
//  Description : Two-stage candidate selector. Stage 1 compacts a slot
//                bitmask into an ascending index table plus popcount;
//                stage 2 picks one slot (random / round-robin / lowest /
//                highest). Valid/ready on both sides with full back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module esm_candidate_selector #(
    parameter int BS    = 16,
    parameter int RND_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [BS-1:0]            req_candidates,
    input  logic [RND_W-1:0]         req_random,
    input  logic [1:0]               req_mode,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(BS)-1:0]    res_index,
    output logic [$clog2(BS):0]      res_count,
    output logic                     res_empty
);

    localparam int IDX_W = $clog2(BS);
    localparam int CNT_W = IDX_W + 1;
    // Common width for the modulo so neither operand is truncated.
    localparam int MOD_W = (RND_W > CNT_W) ? RND_W : CNT_W;

    localparam logic [1:0] MODE_RANDOM  = 2'd0;
    localparam logic [1:0] MODE_RR      = 2'd1;
    localparam logic [1:0] MODE_LOWEST  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Stage 1 registers
    logic                s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]    s1_table_q [BS];
    logic [CNT_W-1:0]    s1_count_q;
    logic [RND_W-1:0]    s1_random_q;
    logic [1:0]          s1_mode_q;

    // Stage 2 (result) registers
    logic                res_valid_q, res_valid_d;
    logic [IDX_W-1:0]    res_index_q;
    logic [CNT_W-1:0]    res_count_q;
    logic                res_empty_q;
    logic [IDX_W-1:0]    rr_ptr_q;

    // Combinational helpers
    logic [IDX_W-1:0]    w_table [BS];
    logic [CNT_W-1:0]    w_cnt;
    logic                w_s1_advance;
    logic                w_req_fire;
    logic                w_s2_load;
    logic [CNT_W-1:0]    w_div;
    logic [MOD_W-1:0]    w_mod;
    logic [IDX_W-1:0]    w_sel;

    assign w_s1_advance = !res_valid_q || res_ready;
    assign req_ready    = !s1_valid_q || w_s1_advance;
    assign w_req_fire   = req_valid && req_ready;
    assign w_s2_load    = s1_valid_q && w_s1_advance;

    // Compact the incoming bitmask into an ascending index table and popcount.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < BS; i++) begin
            w_table[i] = '0;
        end
        for (int i = 0; i < BS; i++) begin
            if (req_candidates[i]) begin
                w_table[w_cnt[IDX_W-1:0]] = IDX_W'(i);
                w_cnt = w_cnt + CNT_ONE;
            end
        end
    end

    // Next-state of the two valid flags; flush wins over any load.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        res_valid_d = res_valid_q;
        if (flush) begin
            s1_valid_d  = 1'b0;
            res_valid_d = 1'b0;
        end else begin
            if (w_req_fire) begin
                s1_valid_d = 1'b1;
            end else if (w_s1_advance) begin
                s1_valid_d = 1'b0;
            end
            if (w_s2_load) begin
                res_valid_d = 1'b1;
            end else if (res_ready) begin
                res_valid_d = 1'b0;
            end
        end
    end

    // Slot selection from the stage-1 table; divisor forced to 1 when empty
    // so the modulo never sees zero (the result is masked by res_empty anyway).
    always_comb begin
        w_div = (s1_count_q == '0) ? CNT_ONE : s1_count_q;
        w_mod = MOD_W'(s1_random_q) % MOD_W'(w_div);
        w_sel = '0;
        case (s1_mode_q)
            MODE_RANDOM: begin
                for (int k = 0; k < BS; k++) begin
                    if (MOD_W'(k) == w_mod) begin
                        w_sel = s1_table_q[k];
                    end
                end
            end
            MODE_RR: begin
                // Wrap to the lowest entry unless a higher one follows rr_ptr.
                w_sel = s1_table_q[0];
                for (int k = BS - 1; k >= 0; k--) begin
                    if ((CNT_W'(k) < s1_count_q) && (s1_table_q[k] > rr_ptr_q)) begin
                        w_sel = s1_table_q[k];
                    end
                end
            end
            MODE_LOWEST: begin
                w_sel = s1_table_q[0];
            end
            default: begin
                for (int k = 0; k < BS; k++) begin
                    if (CNT_W'(k) == (s1_count_q - CNT_ONE)) begin
                        w_sel = s1_table_q[k];
                    end
                end
            end
        endcase
    end

    // Stage 1 capture: table, count, random and mode registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_count_q  <= '0;
            s1_random_q <= '0;
            s1_mode_q   <= '0;
            for (int k = 0; k < BS; k++) begin
                s1_table_q[k] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            if (w_req_fire && !flush) begin
                s1_count_q  <= w_cnt;
                s1_random_q <= req_random;
                s1_mode_q   <= req_mode;
                for (int k = 0; k < BS; k++) begin
                    s1_table_q[k] <= w_table[k];
                end
            end
        end
    end

    // Stage 2 result and round-robin pointer; pointer moves only on a
    // non-empty round-robin result actually being loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_count_q <= '0;
            res_empty_q <= 1'b0;
            rr_ptr_q    <= IDX_W'(BS - 1);
        end else begin
            res_valid_q <= res_valid_d;
            if (w_s2_load && !flush) begin
                res_count_q <= s1_count_q;
                res_empty_q <= (s1_count_q == '0);
                res_index_q <= (s1_count_q == '0) ? '0 : w_sel;
                if ((s1_mode_q == MODE_RR) && (s1_count_q != '0)) begin
                    rr_ptr_q <= w_sel;
                end
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_index = res_index_q;
    assign res_count = res_count_q;
    assign res_empty = res_empty_q;

endmodule
`default_nettype wire

// File: tb/tb_esm_candidate_selector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_esm_candidate_selector
//  Description : Directed self-checking bench for esm_candidate_selector
//                with a queue of hand-computed expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_esm_candidate_selector;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_candidates;
    logic [7:0]  req_random;
    logic [1:0]  req_mode;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_index;
    logic [4:0]  res_count;
    logic        res_empty;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0] idx;
        logic [4:0] cnt;
        logic       empty;
    } exp_t;

    exp_t exp_q[$];

    esm_candidate_selector #(
        .BS    (16),
        .RND_W (8)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_candidates (req_candidates),
        .req_random     (req_random),
        .req_mode       (req_mode),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_index      (res_index),
        .res_count      (res_count),
        .res_empty      (res_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Result monitor: every consumed result must match the next expectation.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("res_index", 32'(res_index), 32'(e.idx));
                check_eq("res_count", 32'(res_count), 32'(e.cnt));
                check_eq("res_empty", 32'(res_empty), 32'(e.empty));
            end
        end
    end

    // Present one request and hold it until accepted; called at posedge+1,
    // returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] cand, input logic [7:0] rnd, input logic [1:0] mode,
                        input logic [3:0] ei, input logic [4:0] ec, input logic ee);
        bit done;
        done           = 1'b0;
        req_candidates = cand;
        req_random     = rnd;
        req_mode       = mode;
        req_valid      = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(exp_t'{ei, ec, ee});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        flush          = 1'b0;
        req_valid      = 1'b0;
        req_candidates = '0;
        req_random     = '0;
        req_mode       = '0;
        res_ready      = 1'b1;

        // Reset state
        tick(3);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_index", 32'(res_index), 32'd0);
        check_eq("rst_res_count", 32'(res_count), 32'd0);
        check_eq("rst_res_empty", 32'(res_empty), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        tick(1);

        // Random mode and latency: 7 % 4 = 3 -> slot 11
        send(16'h0A50, 8'd7, 2'd0, 4'd11, 5'd4, 1'b0);
        check_eq("lat_after_accept", 32'(res_valid), 32'd0);
        tick(1);
        check_eq("lat_second_edge", 32'(res_valid), 32'd1);
        drain();

        // Lowest / highest and single candidate in every mode
        send(16'h0A50, 8'd0, 2'd2, 4'd4,  5'd4, 1'b0);
        send(16'h0A50, 8'd0, 2'd3, 4'd11, 5'd4, 1'b0);
        send(16'h8000, 8'd7, 2'd0, 4'd15, 5'd1, 1'b0);
        send(16'h8000, 8'd0, 2'd1, 4'd15, 5'd1, 1'b0);
        send(16'h8000, 8'd0, 2'd2, 4'd15, 5'd1, 1'b0);
        send(16'h8000, 8'd0, 2'd3, 4'd15, 5'd1, 1'b0);
        drain();

        // Round-robin back-to-back (pointer starts at 15), then interleaved lowest
        send(16'h0A50, 8'd0, 2'd1, 4'd4,  5'd4, 1'b0);
        send(16'h0A50, 8'd0, 2'd1, 4'd6,  5'd4, 1'b0);
        send(16'h0A50, 8'd0, 2'd1, 4'd9,  5'd4, 1'b0);
        send(16'h0A50, 8'd0, 2'd1, 4'd11, 5'd4, 1'b0);
        send(16'h0A50, 8'd0, 2'd1, 4'd4,  5'd4, 1'b0);
        send(16'h0A50, 8'd0, 2'd2, 4'd4,  5'd4, 1'b0);
        send(16'h0A50, 8'd0, 2'd1, 4'd6,  5'd4, 1'b0);
        drain();

        // Full mask: 200 % 16 = 8; empty mask in every mode leaves rr at 6
        send(16'hFFFF, 8'd200, 2'd0, 4'd8, 5'd16, 1'b0);
        for (int m = 0; m < 4; m++) begin
            send(16'h0000, 8'd5, 2'(m), 4'd0, 5'd0, 1'b1);
        end
        send(16'h0A50, 8'd0, 2'd1, 4'd9, 5'd4, 1'b0);
        drain();

        // Back-pressure: two accepted, third stalls with outputs stable
        tick(1);
        res_ready = 1'b0;
        send(16'h0A50, 8'd0,   2'd2, 4'd4,  5'd4,  1'b0);
        send(16'h0A50, 8'd0,   2'd3, 4'd11, 5'd4,  1'b0);
        req_candidates = 16'hFFFF;
        req_random     = 8'd200;
        req_mode       = 2'd0;
        req_valid      = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check_eq("bp_req_ready", 32'(req_ready), 32'd0);
            check_eq("bp_res_valid", 32'(res_valid), 32'd1);
            check_eq("bp_res_index", 32'(res_index), 32'd4);
            check_eq("bp_res_count", 32'(res_count), 32'd4);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(16'hFFFF, 8'd200, 2'd0, 4'd8, 5'd16, 1'b0);
        drain();

        // Flush with two in flight; rr pointer (9) survives
        tick(1);
        res_ready = 1'b0;
        send(16'h0A50, 8'd0, 2'd2, 4'd4,  5'd4, 1'b0);
        send(16'h0A50, 8'd0, 2'd3, 4'd11, 5'd4, 1'b0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check_eq("flush_res_valid", 32'(res_valid), 32'd0);
        exp_q.delete();
        res_ready = 1'b1;
        tick(3);
        check_eq("flush_idle", 32'(res_valid), 32'd0);
        send(16'h0A50, 8'd0, 2'd1, 4'd11, 5'd4, 1'b0);
        drain();

        // Asynchronous reset mid-stream
        tick(1);
        res_ready = 1'b0;
        send(16'h0A50, 8'd0, 2'd2, 4'd4, 5'd4, 1'b0);
        tick(1);
        check_eq("pre_rst_index", 32'(res_index), 32'd4);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_res_valid", 32'(res_valid), 32'd0);
        check_eq("arst_res_index", 32'(res_index), 32'd0);
        check_eq("arst_res_count", 32'(res_count), 32'd0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        res_ready = 1'b1;
        tick(1);
        check_eq("arst_req_ready", 32'(req_ready), 32'd1);
        send(16'h0A50, 8'd0, 2'd1, 4'd4, 5'd4, 1'b0);
        drain();

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
